vlsu_txn_tracker: RTL and testbench

- Tracks outstanding AXI bursts for the vector load/store unit, with one independent tracker for loads (AR/R) and one for stores (AW/B).
- Tracker depth and vector-instruction ID width are parametrised.
- Maps each completed burst back to its vector instruction and pulses per-instruction load/store completion to the dispatcher/sequencer.
- Sits between addrgen, the AXI response channels and the vldu/vstu completion logic, and drives store_pending for the dispatcher.

---
 rtl/vlsu_txn_tracker.sv | 139 +++++++++++++
 tb/tb_vlsu_txn_tracker.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vlsu_txn_tracker.sv
// vlsu_txn_tracker: outstanding AXI burst tracker for the vector load/store unit.
// Two identical, independent circular FIFOs: index 0 tracks loads (AR/R),
// index 1 tracks stores (AW/B). Each entry holds {id, last}. When an entry with
// last=1 retires, the owning instruction's completion is pulsed one cycle later.
//
// Handshake semantics: *_issue_valid_i reports an address handshake that has
// already happened upstream. Upstream must only let it occur while the matching
// *_issue_ready_o is 1. ready is a pure function of the registered count, so a
// response retiring in the same cycle never makes room early. r_last_i/b_valid_i
// report completed response handshakes and are never back-pressured.
module vlsu_txn_tracker #(
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned NrVInsn        = 8,
    localparam int unsigned IdWidth       = (NrVInsn > 1) ? $clog2(NrVInsn) : 1,
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ld_issue_valid_i,
    input  logic                ld_issue_last_i,
    input  logic [IdWidth-1:0]  ld_issue_id_i,
    output logic                ld_issue_ready_o,
    input  logic                r_last_i,
    input  logic                st_issue_valid_i,
    input  logic                st_issue_last_i,
    input  logic [IdWidth-1:0]  st_issue_id_i,
    output logic                st_issue_ready_o,
    input  logic                b_valid_i,
    output logic                load_complete_o,
    output logic [IdWidth-1:0]  load_complete_id_o,
    output logic                store_complete_o,
    output logic [IdWidth-1:0]  store_complete_id_o,
    output logic                store_pending_o,
    output logic [CntWidth-1:0] ld_count_o,
    output logic [CntWidth-1:0] st_count_o,
    output logic                err_o
);

    localparam int unsigned PtrWidth = $clog2(MaxOutstanding);
    localparam logic [CntWidth-1:0] CntFull = CntWidth'(MaxOutstanding);

    // Per-tracker views of the ports: index 0 = load, index 1 = store
    logic [1:0]                issue_valid;
    logic [1:0]                issue_last;
    logic [1:0][IdWidth-1:0]   issue_id;
    logic [1:0]                resp;
    logic [1:0]                trk_ready;
    logic [1:0][CntWidth-1:0]  trk_count;
    logic [1:0]                trk_complete;
    logic [1:0][IdWidth-1:0]   trk_complete_id;
    logic [1:0]                empty_pop;
    logic                      err_q;

    assign issue_valid = {st_issue_valid_i, ld_issue_valid_i};
    assign issue_last  = {st_issue_last_i, ld_issue_last_i};
    assign issue_id    = {st_issue_id_i, ld_issue_id_i};
    assign resp        = {b_valid_i, r_last_i};

    for (genvar t = 0; t < 2; t++) begin : g_trk
        logic [IdWidth-1:0]        mem_id [MaxOutstanding];
        logic [MaxOutstanding-1:0] mem_last;
        logic [PtrWidth-1:0]       rd_ptr;
        logic [PtrWidth-1:0]       wr_ptr;
        logic [CntWidth-1:0]       count;
        logic                      complete_q;
        logic [IdWidth-1:0]        complete_id_q;
        logic                      ready;
        logic                      push;
        logic                      pop;

        assign ready        = (count != CntFull);
        assign push         = issue_valid[t] && ready;
        assign pop          = resp[t] && (count != '0);
        assign empty_pop[t] = resp[t] && (count == '0);

        // Entry storage: contents are only meaningful between wr_ptr and rd_ptr
        always_ff @(posedge clk_i) begin
            if (push) begin
                mem_id[wr_ptr]   <= issue_id[t];
                mem_last[wr_ptr] <= issue_last[t];
            end
        end

        // Pointers, occupancy and the registered completion pulse
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rd_ptr        <= '0;
                wr_ptr        <= '0;
                count         <= '0;
                complete_q    <= 1'b0;
                complete_id_q <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PtrWidth'(1);
                if (pop)  rd_ptr <= rd_ptr + PtrWidth'(1);
                case ({push, pop})
                    2'b10:   count <= count + CntWidth'(1);
                    2'b01:   count <= count - CntWidth'(1);
                    default: count <= count;
                endcase
                complete_q <= pop && mem_last[rd_ptr];
                if (pop && mem_last[rd_ptr]) complete_id_q <= mem_id[rd_ptr];
            end
        end

        // Issuing into a full tracker means upstream ignored ready; the burst is dropped
        always @(posedge clk_i) begin
            if (rst_ni) begin
                assert (!(issue_valid[t] && !ready))
                    else $warning("vlsu_txn_tracker: issue while tracker %0d is full", t);
            end
        end

        assign trk_ready[t]       = ready;
        assign trk_count[t]       = count;
        assign trk_complete[t]    = complete_q;
        assign trk_complete_id[t] = complete_id_q;
    end

    // Sticky error: any response arriving with nothing outstanding
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (|empty_pop) begin
            err_q <= 1'b1;
        end
    end

    assign ld_issue_ready_o    = trk_ready[0];
    assign st_issue_ready_o    = trk_ready[1];
    assign ld_count_o          = trk_count[0];
    assign st_count_o          = trk_count[1];
    assign load_complete_o     = trk_complete[0];
    assign load_complete_id_o  = trk_complete_id[0];
    assign store_complete_o    = trk_complete[1];
    assign store_complete_id_o = trk_complete_id[1];
    assign store_pending_o     = (trk_count[1] != '0);
    assign err_o               = err_q;

endmodule

// File: tb/tb_vlsu_txn_tracker.sv
// Directed bench for vlsu_txn_tracker (MaxOutstanding=8, NrVInsn=8).
module tb_vlsu_txn_tracker;

    localparam int IdWidth  = 3;
    localparam int CntWidth = 4;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                ld_issue_valid, ld_issue_last, ld_issue_ready;
    logic [IdWidth-1:0]  ld_issue_id;
    logic                r_last;
    logic                st_issue_valid, st_issue_last, st_issue_ready;
    logic [IdWidth-1:0]  st_issue_id;
    logic                b_valid;
    logic                load_complete, store_complete, store_pending, err;
    logic [IdWidth-1:0]  load_complete_id, store_complete_id;
    logic [CntWidth-1:0] ld_count, st_count;

    int checks = 0;
    int errors = 0;

    vlsu_txn_tracker #(.MaxOutstanding(8), .NrVInsn(8)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .ld_issue_valid_i    (ld_issue_valid),
        .ld_issue_last_i     (ld_issue_last),
        .ld_issue_id_i       (ld_issue_id),
        .ld_issue_ready_o    (ld_issue_ready),
        .r_last_i            (r_last),
        .st_issue_valid_i    (st_issue_valid),
        .st_issue_last_i     (st_issue_last),
        .st_issue_id_i       (st_issue_id),
        .st_issue_ready_o    (st_issue_ready),
        .b_valid_i           (b_valid),
        .load_complete_o     (load_complete),
        .load_complete_id_o  (load_complete_id),
        .store_complete_o    (store_complete),
        .store_complete_id_o (store_complete_id),
        .store_pending_o     (store_pending),
        .ld_count_o          (ld_count),
        .st_count_o          (st_count),
        .err_o               (err)
    );

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ld_issue_valid = 1'b0; ld_issue_last = 1'b0; ld_issue_id = '0; r_last = 1'b0;
        st_issue_valid = 1'b0; st_issue_last = 1'b0; st_issue_id = '0; b_valid = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            end
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #22;
        rst_n = 1'b1;
        tick();

        // Reset then idle
        chk("rst_ld_ready", ld_issue_ready, 1);
        chk("rst_st_ready", st_issue_ready, 1);
        chk("rst_ld_count", ld_count, 0);
        chk("rst_st_count", st_count, 0);
        chk("rst_pending", store_pending, 0);
        chk("rst_err", err, 0);
        chk("rst_ld_cmp", load_complete, 0);
        chk("rst_st_cmp", store_complete, 0);
        chk("rst_ld_cmp_id", load_complete_id, 0);

        // Load ID 3, three bursts, last on the third
        ld_issue_valid = 1'b1; ld_issue_id = 3'd3; ld_issue_last = 1'b0;
        tick(); chk("ld3_cnt1", ld_count, 1);
        tick(); chk("ld3_cnt2", ld_count, 2);
        ld_issue_last = 1'b1;
        tick(); chk("ld3_cnt3", ld_count, 3);
        ld_issue_valid = 1'b0; ld_issue_last = 1'b0;
        r_last = 1'b1;
        tick(); chk("ld3_pop_cnt2", ld_count, 2); chk("ld3_no_cmp1", load_complete, 0);
        tick(); chk("ld3_pop_cnt1", ld_count, 1); chk("ld3_no_cmp2", load_complete, 0);
        tick(); chk("ld3_pop_cnt0", ld_count, 0);
        chk("ld3_cmp", load_complete, 1); chk("ld3_cmp_id", load_complete_id, 3);
        r_last = 1'b0;
        tick(); chk("ld3_cmp_low", load_complete, 0); chk("ld3_id_hold", load_complete_id, 3);
        chk("ld3_err", err, 0);

        // Fill the store tracker
        st_issue_valid = 1'b1; st_issue_last = 1'b1;
        for (int i = 0; i < 8; i++) begin
            st_issue_id = 3'(i);
            tick();
        end
        chk("full_cnt", st_count, 8);
        chk("full_ready", st_issue_ready, 0);
        chk("full_pending", store_pending, 1);
        chk("full_ld_ready", ld_issue_ready, 1);
        // Push while full alongside a pop: push dropped, one entry retired
        st_issue_id = 3'd6; b_valid = 1'b1;
        tick();
        chk("full_pop_cnt", st_count, 7);
        chk("full_pop_ready", st_issue_ready, 1);
        chk("full_pop_cmp", store_complete, 1);
        chk("full_pop_cmp_id", store_complete_id, 0);
        st_issue_valid = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("drain_id", store_complete_id, i);
            chk("drain_cmp", store_complete, 1);
        end
        chk("drain_cnt", st_count, 0);
        chk("drain_pending", store_pending, 0);
        chk("drain_err", err, 0);
        b_valid = 1'b0;
        tick(); chk("drain_cmp_low", store_complete, 0);

        // Steady state at count 4 with pointer wrap
        st_issue_valid = 1'b1; st_issue_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st_issue_id = 3'(i);
            tick();
        end
        chk("ss_cnt4", st_count, 4);
        b_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            st_issue_id = 3'((k + 4) % 8);
            tick();
            chk("ss_cnt", st_count, 4);
            chk("ss_cmp_id", store_complete_id, k % 8);
        end
        st_issue_valid = 1'b0;
        for (int k = 20; k < 24; k++) begin
            tick();
            chk("ss_drain_id", store_complete_id, k % 8);
            chk("ss_drain_cnt", st_count, 23 - k);
        end
        b_valid = 1'b0;
        tick();
        chk("ss_err", err, 0);

        // Response into an empty tracker, including the push-to-empty cycle
        st_issue_valid = 1'b1; st_issue_id = 3'd5; st_issue_last = 1'b1; b_valid = 1'b1;
        tick();
        chk("e_push_err", err, 1);
        chk("e_push_cnt", st_count, 1);
        chk("e_push_nocmp", store_complete, 0);
        st_issue_valid = 1'b0;
        tick();
        chk("e_pop_cnt", st_count, 0);
        chk("e_pop_cmp", store_complete, 1);
        chk("e_pop_cmp_id", store_complete_id, 5);
        tick();
        chk("e_empty_cnt", st_count, 0);
        chk("e_empty_nocmp", store_complete, 0);
        chk("e_ld_cnt", ld_count, 0);
        b_valid = 1'b0;
        tick(); tick();
        chk("e_err_sticky", err, 1);

        // Interleaved single-burst load ID 1 and store ID 2
        ld_issue_valid = 1'b1; ld_issue_id = 3'd1; ld_issue_last = 1'b1;
        st_issue_valid = 1'b1; st_issue_id = 3'd2; st_issue_last = 1'b1;
        tick();
        chk("il_ld_cnt", ld_count, 1);
        chk("il_st_cnt", st_count, 1);
        chk("il_pending", store_pending, 1);
        idle_inputs();
        r_last = 1'b1; b_valid = 1'b1;
        tick();
        chk("il_ld_cmp", load_complete, 1);
        chk("il_ld_id", load_complete_id, 1);
        chk("il_st_cmp", store_complete, 1);
        chk("il_st_id", store_complete_id, 2);
        chk("il_st_cnt0", st_count, 0);
        chk("il_pending0", store_pending, 0);
        idle_inputs();
        tick();

        // Reset mid-operation discards the outstanding entry
        ld_issue_valid = 1'b1; ld_issue_id = 3'd4; ld_issue_last = 1'b1;
        tick();
        chk("mr_ld_cnt", ld_count, 1);
        idle_inputs();
        r_last = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mr_ld_cnt0", ld_count, 0);
        chk("mr_err0", err, 0);
        tick();
        chk("mr_nocmp", load_complete, 0);
        idle_inputs();
        #3;
        rst_n = 1'b1;
        tick();
        chk("mr_nocmp2", load_complete, 0);
        chk("mr_ready", ld_issue_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
